// File: rtl/wave_gen_if.sv
// wave_gen_if -- control/sample bundle for the wave_gen waveform source.
//   enable     : run; low freezes sample generation
//   phase_clr  : clear phase accumulator on next edge
//   wave_sel   : 00 sine, 01 square, 10 sawtooth, 11 triangle
//   phase_inc  : unsigned phase step per sample
//   amplitude  : unsigned gain, 32768 = unity (larger values clamp)
//   new_data   : one-cycle strobe marking a fresh x_out
//   x_out      : signed Q1.15 sample
// master drives the controls and consumes samples; slave is the generator.
interface wave_gen_if #(
  parameter int unsigned PHASE_W = 32
);
  logic                enable;
  logic                phase_clr;
  logic [1:0]          wave_sel;
  logic [PHASE_W-1:0]  phase_inc;
  logic [15:0]         amplitude;
  logic                new_data;
  logic signed [15:0]  x_out;

  modport master (
    output enable, phase_clr, wave_sel, phase_inc, amplitude,
    input  new_data, x_out
  );

  modport slave (
    input  enable, phase_clr, wave_sel, phase_inc, amplitude,
    output new_data, x_out
  );
endinterface

// File: rtl/wave_gen.sv
// wave_gen -- DDS-style waveform generator producing one Q1.15 sample every
// CLK_DIV clocks. A phase accumulator advances by phase_inc per sample; its
// top 16 bits select a sine/square/sawtooth/triangle value, which is scaled
// by amplitude. Two-stage pipeline: tick captures controls and phase, the
// next cycle shapes/scales, and new_data/x_out appear two clocks after tick.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : wave_gen_if.slave (controls in, new_data/x_out out)
module wave_gen #(
  parameter int unsigned CLK_DIV = 1000,
  parameter int unsigned PHASE_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  wave_gen_if.slave bus
);

  // Quarter-wave sine table, built at elaboration: entry i is
  // round(32767*sin(pi*(2i+1)/1024)) via a Taylor series (positive values,
  // so +0.5 then truncate rounds half away from zero).
  function automatic logic [15:0] sine_entry(input int i);
    real x, term, sum;
    x    = 3.14159265358979323846 * real'(2 * i + 1) / 1024.0;
    term = x;
    sum  = x;
    for (int unsigned n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return 16'($rtoi(32767.0 * sum + 0.5));
  endfunction

  logic [15:0] sin_lut [256];
  for (genvar g = 0; g < 256; g++) begin : g_lut
    localparam logic [15:0] LV = sine_entry(g);
    assign sin_lut[g] = LV;
  end

  localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);

  logic [15:0]        cnt_q, cnt_d;
  logic               tick;
  logic [PHASE_W-1:0] acc_q, acc_d;

  logic               s1_vld_q, s1_vld_d;
  logic [1:0]         s1_sel_q, s1_sel_d;
  logic [16:0]        s1_amp_q, s1_amp_d;
  logic [15:0]        s1_p_q, s1_p_d;

  logic               nd_q, nd_d;
  logic signed [15:0] x_q, x_d;

  // Tick counter and phase accumulator
  always_comb begin
    tick  = bus.enable && (cnt_q == CNT_LAST);
    cnt_d = (!bus.enable || tick) ? '0 : cnt_q + 16'd1;
    acc_d = acc_q;
    if (bus.phase_clr) begin
      acc_d = '0;
    end else if (tick) begin
      acc_d = acc_q + bus.phase_inc;
    end
  end

  // Stage 1: capture controls and the pre-increment phase at tick
  always_comb begin
    s1_vld_d = tick;
    s1_sel_d = s1_sel_q;
    s1_amp_d = s1_amp_q;
    s1_p_d   = s1_p_q;
    if (tick) begin
      s1_sel_d = bus.wave_sel;
      // any amplitude with bit 15 set is >= 32768, i.e. clamps to unity
      s1_amp_d = bus.amplitude[15] ? 17'd32768 : {1'b0, bus.amplitude};
      s1_p_d   = acc_q[PHASE_W-1 -: 16];
    end
  end

  // Stage 2: waveform shaping and amplitude scaling
  logic [1:0]         quad;
  logic [7:0]         idx;
  logic [15:0]        mag;
  logic [14:0]        tri_t;
  logic signed [16:0] raw;
  logic signed [17:0] amp_s;
  logic signed [32:0] prod;

  always_comb begin
    quad  = s1_p_q[15:14];
    // odd quadrants run the table backwards: ~k == 255-k
    idx   = quad[0] ? ~s1_p_q[13:6] : s1_p_q[13:6];
    mag   = sin_lut[idx];
    // for P[15]=1, 0xFFFF-P has bit 15 clear and equals ~P in the low bits
    tri_t = s1_p_q[15] ? ~s1_p_q[14:0] : s1_p_q[14:0];
    raw   = '0;
    unique case (s1_sel_q)
      2'd0: raw = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
      2'd1: raw = s1_p_q[15] ? -17'sd32767 : 17'sd32767;
      // P xor 0x8000 read as signed is P-32768; only P=0 hits -32768
      2'd2: raw = (s1_p_q == 16'h0000) ? -17'sd32767
                                       : $signed({1'b0, s1_p_q}) - 17'sd32768;
      2'd3: raw = $signed({1'b0, tri_t, 1'b0}) - 17'sd32767;
    endcase
    amp_s = $signed({1'b0, s1_amp_q});
    prod  = 33'(raw) * 33'(amp_s);
    nd_d  = s1_vld_q;
    x_d   = s1_vld_q ? 16'(prod >>> 15) : x_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_sel_q <= '0;
      s1_amp_q <= '0;
      s1_p_q   <= '0;
      nd_q     <= 1'b0;
      x_q      <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      s1_vld_q <= s1_vld_d;
      s1_sel_q <= s1_sel_d;
      s1_amp_q <= s1_amp_d;
      s1_p_q   <= s1_p_d;
      nd_q     <= nd_d;
      x_q      <= x_d;
    end
  end

  assign bus.new_data = nd_q;
  assign bus.x_out    = x_q;

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter CLK_DIV, default 1000: clocks per output sample; legal range 2..65535.
REQ-002 Parameter PHASE_W, default 32: phase accumulator width; top 16 bits form phase P.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  run; low freezes sample generation.
REQ-006 phase_clr  input  1  clears phase accumulator to 0.
REQ-007 wave_sel  input  2  00 sine, 01 square, 10 sawtooth, 11 triangle.
REQ-008 phase_inc  input  PHASE_W  unsigned phase step per sample.
REQ-009 amplitude  input  16  unsigned gain; 32768 = unity; values above 32768 are treated as 32768.
REQ-010 new_data  output  1  one-cycle strobe marking a new x_out; feeds downstream filter new_data.
REQ-011 x_out  signed output  16  sample, Q1.15.

Function
REQ-012 Tick counter SHALL count 0..CLK_DIV-1 while enable=1; internal tick fires in the cycle where counter = CLK_DIV-1, after which counter wraps to 0.
REQ-013 While enable=0: counter SHALL hold 0, no tick, accumulator holds; samples already in the pipeline SHALL complete normally.
REQ-014 At tick: wave_sel, amplitude and P (accumulator before increment) SHALL be captured; accumulator <= acc + phase_inc, modulo 2^PHASE_W (wrap, no saturation).
REQ-015 phase_clr=1 SHALL set accumulator to 0 on the next edge, overriding any tick increment in that cycle; the sample captured at that tick still uses the pre-clear P.
REQ-016 new_data SHALL assert exactly 2 clk after the tick cycle, for exactly 1 cycle; x_out SHALL update in that same cycle and hold otherwise.
REQ-017 Sine: quadrant q = P[15:14], k = P[13:6]; LUT[i] = round-half-away(32767*sin(pi*(2i+1)/1024)), i = 0..255; q0 LUT[k], q1 LUT[255-k], q2 -LUT[k], q3 -LUT[255-k].
REQ-018 Square: raw = +32767 when P[15]=0, else -32767.
REQ-019 Sawtooth: raw = signed(P XOR 0x8000), with -32768 saturated to -32767.
REQ-020 Triangle: t = P[15] ? (0xFFFF - P) : P, giving 0..32767; raw = 2t - 32767.
REQ-021 Output: x_out = (raw * amp) >>> 15, using a 33-bit signed product and arithmetic (floor) shift; amp = min(amplitude, 32768); result always within ±32767.
REQ-022 Changing wave_sel, phase_inc or amplitude between ticks SHALL affect only samples whose tick follows the change.

Reset
REQ-023 While rst_n=0 at an edge: counter 0, accumulator 0, pipeline cleared, new_data 0, x_out 0.
REQ-024 Reset mid-pipeline SHALL discard pending samples; no new_data SHALL issue for a tick preceding the reset.
REQ-025 After release with enable=1, the first tick SHALL occur CLK_DIV cycles later; the first sample SHALL use P = 0.

Verification
REQ-026 Square, CLK_DIV=4, phase_inc=0x40000000, amplitude=32768 -> new_data every 4 clk; x_out +32767, +32767, -32767, -32767, repeating.
REQ-027 Same setup, sawtooth -> -32767, -16384, 0, 16384 repeating; triangle -> -32767, 1, 32767, -1 repeating.
REQ-028 Sine, phase_inc=0x40000000, amplitude=32768 -> first samples 101, 32767, -101, -32767.
REQ-029 Square, amplitude=16384 -> +16383 / -16384; amplitude=0xFFFF -> same output as amplitude=32768.
REQ-030 Boundary conditions:
- enable dropped for 10 cycles mid-run -> pending sample still issues; no further strobes; sequence then resumes with the next phase and no skip.
- phase_clr pulsed together with a tick -> the next sample uses P = 0.
- rst_n low one cycle after a tick -> no strobe is issued; x_out = 0.
- Strobe spacing is always exactly CLK_DIV cycles while enabled.
